// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / stall / flush controller for a five-stage pipeline.
// Produces per-stage hold and bubble (NOP insert) enables from fetch, memory,
// multi-cycle EX, branch-redirect and load-use conditions.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating stall/flush counters;
// when undefined the counter outputs are tied to zero and no counter state exists.
// Stage bit map for hold/bubble: 0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read_en,
  input  logic        id_reg2_read_en,
  input  logic [4:0]  id_reg1_addr,
  input  logic [4:0]  id_reg2_addr,
  input  logic        ex_is_load,
  input  logic        ex_reg_write_en,
  input  logic [4:0]  ex_reg_write_addr,
  input  logic        ex_multi_start,
  input  logic [5:0]  ex_multi_cycles,
  input  logic        ex_branch_flush,
  input  logic        if_stall_req,
  input  logic        mem_stall_req,
  output logic [4:0]  hold,
  output logic [4:0]  bubble,
  output logic        ex_busy,
  output logic        ex_multi_done,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       flush_pending_q, flush_pending_d;
  logic       load_use;
  logic       blocked;
  logic       flush_issue;
  logic [4:0] hold_raw, bubble_raw;

  // State register: multi-cycle FSM, remaining-cycle counter and deferred flush flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= 6'd0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Multi-cycle EX sequencing; a memory stall freezes the whole sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ex_busy       = 1'b0;
    ex_multi_done = 1'b0;
    if (state_q == IDLE) begin
      if (ex_multi_start && !mem_stall_req) begin
        if (ex_multi_cycles >= 6'd2) begin
          ex_busy = 1'b1;
          state_d = BUSY;
          cnt_d   = ex_multi_cycles - 6'd1;
        end else begin
          ex_multi_done = 1'b1;
        end
      end
    end else begin
      if (mem_stall_req) begin
        ex_busy = 1'b1;
      end else if (cnt_q > 6'd1) begin
        ex_busy = 1'b1;
        cnt_d   = cnt_q - 6'd1;
      end else begin
        // cnt_q==1 is the last EX cycle; cnt_q==0 cannot occur but recovers to IDLE.
        ex_multi_done = (cnt_q == 6'd1);
        state_d       = IDLE;
        cnt_d         = 6'd0;
      end
    end
    if (!rst) begin
      ex_busy       = 1'b0;
      ex_multi_done = 1'b0;
    end
  end

  // Hazard detection and flush arbitration; a flush waits while EX or MEM is blocked.
  always_comb begin
    load_use = ex_is_load && ex_reg_write_en && (ex_reg_write_addr != 5'd0) &&
               ((id_reg1_read_en && (id_reg1_addr == ex_reg_write_addr)) ||
                (id_reg2_read_en && (id_reg2_addr == ex_reg_write_addr)));
    blocked     = mem_stall_req || ex_busy;
    flush_issue = !blocked && (ex_branch_flush || flush_pending_q);
    // A request arriving on the issue cycle merges into the flush being issued.
    flush_pending_d = flush_issue ? 1'b0 : (flush_pending_q || ex_branch_flush);
  end

  // Priority-ordered hold/bubble generation; bubble wins on any shared bit.
  always_comb begin
    hold_raw   = 5'b00000;
    bubble_raw = 5'b00000;
    if (mem_stall_req) begin
      hold_raw   = 5'b01111;
      bubble_raw = 5'b10000;
    end else if (ex_busy) begin
      hold_raw   = 5'b00111;
      bubble_raw = 5'b01000;
    end else if (flush_issue) begin
      hold_raw   = {4'b0000, if_stall_req};
      bubble_raw = 5'b00110;
    end else if (load_use) begin
      hold_raw   = 5'b00011;
      bubble_raw = 5'b00100;
    end else if (if_stall_req) begin
      hold_raw   = 5'b00001;
      bubble_raw = 5'b00010;
    end
    hold   = hold_raw & ~bubble_raw;
    bubble = bubble_raw;
    if (!rst) begin
      hold   = 5'b00000;
      bubble = 5'b11111;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  // Saturating performance counters: PC-hold cycles and issued flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (hold[0] && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_issue && (flush_count_q != 32'hFFFF_FFFF))
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic for pipe_ctrl, checked
// against a behavioural model that tracks "EX cycles still owed", a pending-flush
// flag and plain integer counters.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        id_reg1_read_en, id_reg2_read_en;
  logic [4:0]  id_reg1_addr, id_reg2_addr;
  logic        ex_is_load, ex_reg_write_en;
  logic [4:0]  ex_reg_write_addr;
  logic        ex_multi_start;
  logic [5:0]  ex_multi_cycles;
  logic        ex_branch_flush, if_stall_req, mem_stall_req;
  logic [4:0]  hold, bubble;
  logic        ex_busy, ex_multi_done;
  logic [31:0] stall_cycles, flush_count;

  pipe_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .id_reg1_read_en   (id_reg1_read_en),
    .id_reg2_read_en   (id_reg2_read_en),
    .id_reg1_addr      (id_reg1_addr),
    .id_reg2_addr      (id_reg2_addr),
    .ex_is_load        (ex_is_load),
    .ex_reg_write_en   (ex_reg_write_en),
    .ex_reg_write_addr (ex_reg_write_addr),
    .ex_multi_start    (ex_multi_start),
    .ex_multi_cycles   (ex_multi_cycles),
    .ex_branch_flush   (ex_branch_flush),
    .if_stall_req      (if_stall_req),
    .mem_stall_req     (mem_stall_req),
    .hold              (hold),
    .bubble            (bubble),
    .ex_busy           (ex_busy),
    .ex_multi_done     (ex_multi_done),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  typedef struct packed {
    bit       en1, en2;
    bit [4:0] a1, a2;
    bit       ld, we;
    bit [4:0] wa;
    bit       st;
    bit [5:0] n;
    bit       br, ifs, mems;
  } stim_t;

  stim_t s;
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state
  int      m_left;     // EX cycles the multi-cycle op still occupies (0 = none)
  bit      m_pend;     // a branch redirect is waiting for an unblocked cycle
  longint  m_sc, m_fc; // expected counter values
  bit [4:0] e_hold, e_bub;
  bit       e_busy, e_done, e_fl;

  // Observed values captured at the last sample point
  logic [4:0] o_hold, o_bub;
  logic       o_busy, o_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit lu, blk;
    if (m_left == 0) begin
      e_busy = s.st && (s.n >= 2) && !s.mems;
      e_done = s.st && (s.n < 2) && !s.mems;
    end else begin
      e_busy = (m_left > 1) || s.mems;
      e_done = (m_left == 1) && !s.mems;
    end
    blk  = s.mems || e_busy;
    e_fl = !blk && (s.br || m_pend);
    lu   = s.ld && s.we && (s.wa != 0) &&
           ((s.en1 && s.a1 == s.wa) || (s.en2 && s.a2 == s.wa));
    if (s.mems)       begin e_hold = 5'b01111; e_bub = 5'b10000; end
    else if (e_busy)  begin e_hold = 5'b00111; e_bub = 5'b01000; end
    else if (e_fl)    begin e_hold = {4'b0000, s.ifs}; e_bub = 5'b00110; end
    else if (lu)      begin e_hold = 5'b00011; e_bub = 5'b00100; end
    else if (s.ifs)   begin e_hold = 5'b00001; e_bub = 5'b00010; end
    else              begin e_hold = 5'b00000; e_bub = 5'b00000; end
  endtask

  task automatic model_update();
    if (!s.mems) begin
      if (m_left == 0) begin
        if (s.st && s.n >= 2) m_left = int'(s.n) - 1;
      end else begin
        m_left--;
      end
    end
    m_pend = e_fl ? 1'b0 : (m_pend || s.br);
    if (e_hold[0] && m_sc != 64'hFFFF_FFFF) m_sc++;
    if (e_fl && m_fc != 64'hFFFF_FFFF) m_fc++;
  endtask

  function automatic logic [31:0] exp_cnt(input longint v);
`ifdef PIPE_CTRL_PERF_EN
    return v[31:0];
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // One clock cycle: apply stimulus mid-cycle, compare against model, advance.
  task automatic step(input string tag);
    @(negedge clk);
    id_reg1_read_en   = s.en1;  id_reg2_read_en = s.en2;
    id_reg1_addr      = s.a1;   id_reg2_addr    = s.a2;
    ex_is_load        = s.ld;   ex_reg_write_en = s.we;
    ex_reg_write_addr = s.wa;
    ex_multi_start    = s.st;   ex_multi_cycles = s.n;
    ex_branch_flush   = s.br;   if_stall_req    = s.ifs;
    mem_stall_req     = s.mems;
    #1;
    model_eval();
    o_hold = hold; o_bub = bubble; o_busy = ex_busy; o_done = ex_multi_done;
    chk({tag, ".hold"},    o_hold, e_hold);
    chk({tag, ".bubble"},  o_bub,  e_bub);
    chk({tag, ".busy"},    o_busy, e_busy);
    chk({tag, ".done"},    o_done, e_done);
    chk({tag, ".overlap"}, o_hold & o_bub, 32'd0);
    chk({tag, ".stall_cnt"}, stall_cycles, exp_cnt(m_sc));
    chk({tag, ".flush_cnt"}, flush_count,  exp_cnt(m_fc));
    @(posedge clk);
    model_update();
  endtask

  // Asynchronous reset applied mid-cycle; outputs must take reset values at once.
  task automatic reset_check(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk({tag, ".rst_hold"},   hold,   32'h00);
    chk({tag, ".rst_bubble"}, bubble, 32'h1F);
    chk({tag, ".rst_busy"},   ex_busy, 32'd0);
    chk({tag, ".rst_done"},   ex_multi_done, 32'd0);
    chk({tag, ".rst_scnt"},   stall_cycles, 32'd0);
    chk({tag, ".rst_fcnt"},   flush_count,  32'd0);
    m_left = 0; m_pend = 1'b0; m_sc = 0; m_fc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    s   = '0;
    id_reg1_read_en = 0; id_reg2_read_en = 0; id_reg1_addr = 0; id_reg2_addr = 0;
    ex_is_load = 0; ex_reg_write_en = 0; ex_reg_write_addr = 0;
    ex_multi_start = 0; ex_multi_cycles = 0; ex_branch_flush = 0;
    if_stall_req = 0; mem_stall_req = 0;
    m_left = 0; m_pend = 0; m_sc = 0; m_fc = 0;
    reset_check("init");
    $display("txn init reset");

    // Multi-cycle N=4: three stall cycles, done on the fourth.
    s = '0; s.st = 1; s.n = 6'd4;
    step("n4.c0"); chk("n4.c0.hold_ex", o_hold[2:0], 3'b111);
    s = '0;
    step("n4.c1"); chk("n4.c1.hold_ex", o_hold[2:0], 3'b111);
    step("n4.c2"); chk("n4.c2.hold_ex", o_hold[2:0], 3'b111);
    step("n4.c3"); chk("n4.c3.done", o_done, 1'b1); chk("n4.c3.hold", o_hold, 5'b00000);
    step("n4.c4"); chk("n4.c4.busy", o_busy, 1'b0);
    $display("txn multi N=4");

    // Single-cycle ops N=0 and N=1.
    s = '0; s.st = 1; s.n = 6'd1;
    step("n1"); chk("n1.done", o_done, 1'b1);
    s.n = 6'd0;
    step("n0"); chk("n0.done", o_done, 1'b1);
    $display("txn multi N=0/1");

    // Load-use on reg2 = r5, then a write to r0 which must not stall.
    s = '0; s.ld = 1; s.we = 1; s.wa = 5'd5; s.en2 = 1; s.a2 = 5'd5;
    step("lu.r5"); chk("lu.r5.hold", o_hold, 5'b00011); chk("lu.r5.bub", o_bub, 5'b00100);
    s.wa = 5'd0; s.a2 = 5'd0;
    step("lu.r0"); chk("lu.r0.hold", o_hold, 5'b00000); chk("lu.r0.bub", o_bub, 5'b00000);
    $display("txn load-use");

    // Flush during BUSY N=3 deferred to the done cycle.
    s = '0; s.st = 1; s.n = 6'd3;
    step("fb.c0");
    s = '0; s.br = 1;
    step("fb.c1"); chk("fb.c1.bub", o_bub, 5'b01000);
    s = '0;
    step("fb.c2"); chk("fb.c2.done", o_done, 1'b1); chk("fb.c2.bub", o_bub, 5'b00110);
    step("fb.c3"); chk("fb.c3.bub", o_bub, 5'b00000);
    $display("txn flush during busy");

    // Memory stall for two cycles inside BUSY N=5 delays done by two cycles.
    s = '0; s.st = 1; s.n = 6'd5;
    step("ms.c0"); s = '0;
    step("ms.c1");
    s.mems = 1;
    step("ms.c2"); chk("ms.c2.hold", o_hold, 5'b01111);
    step("ms.c3");
    s = '0;
    step("ms.c4"); chk("ms.c4.done", o_done, 1'b0);
    step("ms.c5"); chk("ms.c5.done", o_done, 1'b0);
    step("ms.c6"); chk("ms.c6.done", o_done, 1'b1);
    $display("txn mem stall in busy");

    // Reset while BUSY with three cycles remaining; no done pulse afterwards.
    s = '0; s.st = 1; s.n = 6'd5;
    step("rb.c0"); s = '0;
    step("rb.c1");
    reset_check("rb");
    for (int i = 0; i < 5; i++) begin
      step("rb.post"); chk("rb.post.done", o_done, 1'b0);
    end
    $display("txn reset mid-busy");

    // Flush and load-use in the same cycle: flush wins.
    s = '0; s.br = 1; s.ld = 1; s.we = 1; s.wa = 5'd7; s.en1 = 1; s.a1 = 5'd7;
    step("fl_lu"); chk("fl_lu.bub", o_bub, 5'b00110); chk("fl_lu.hold1", o_hold[1], 1'b0);
    s = '0; s.br = 1; s.ifs = 1;
    step("fl_ifs"); chk("fl_ifs.hold", o_hold, 5'b00001);
    s = '0; s.ifs = 1;
    step("ifs"); chk("ifs.hold", o_hold, 5'b00001); chk("ifs.bub", o_bub, 5'b00010);
    $display("txn flush priority / fetch stall");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s.en1  = 1'($urandom_range(0, 1));
      s.en2  = 1'($urandom_range(0, 1));
      s.a1   = 5'($urandom_range(0, 3));
      s.a2   = 5'($urandom_range(0, 3));
      s.ld   = ($urandom % 3) == 0;
      s.we   = ($urandom % 4) != 0;
      s.wa   = 5'($urandom_range(0, 3));
      s.st   = ($urandom % 6) == 0;
      s.n    = 6'($urandom_range(0, 7));
      s.br   = ($urandom % 8) == 0;
      s.ifs  = ($urandom % 6) == 0;
      s.mems = ($urandom % 8) == 0;
      step("rnd");
      if (($urandom % 500) == 0) reset_check("rnd");
    end
    $display("txn random 3000 cycles");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
